linecache_pingpong: RTL

Parametrised, double-buffered line cache for the composite video path. The write side fills one line bank with WR_WIDTH-bit words while the read side streams the other bank out as RD_WIDTH-bit elements. A `swap` pulse at the line boundary exchanges the banks. It sits between the pixel fetch logic and the composite serializer, and adds bank management, fill tracking and overflow flagging to the plain single-buffer width-converting line RAM.

---
 rtl/linecache_pkg.sv | 24 ++
 rtl/linecache_sdpram.sv | 43 ++++
 rtl/linecache_pingpong.sv | 107 ++++++++++
 3 files changed

// File: rtl/linecache_pkg.sv
// linecache_pkg: shared width math and parameter legality checks for the ping-pong line cache.
package linecache_pkg;

    function automatic int lc_ratio(input int wr_w, input int rd_w);
        return wr_w / rd_w;
    endfunction

    function automatic int lc_sub_w(input int ratio);
        return ratio > 1 ? $clog2(ratio) : 0;
    endfunction

    function automatic int lc_wr_aw(input int line_words);
        return $clog2(2 * line_words);
    endfunction

    function automatic int lc_rd_aw(input int line_words, input int wr_w, input int rd_w);
        return lc_wr_aw(line_words) + lc_sub_w(lc_ratio(wr_w, rd_w));
    endfunction

    function automatic bit lc_params_ok(input int line_words, input int wr_w, input int rd_w);
        return rd_w > 0 && wr_w % rd_w == 0 && line_words >= 2 && (line_words & (line_words - 1)) == 0;
    endfunction

endpackage

// File: rtl/linecache_sdpram.sv
// linecache_sdpram: single-clock simple dual-port RAM, wide write port, narrow registered read port.
module linecache_sdpram
    import linecache_pkg::*;
#(
    parameter int WR_WIDTH   = 4,
    parameter int RD_WIDTH   = 1,
    parameter int LINE_WORDS = 128,
    localparam int WAW = lc_wr_aw(LINE_WORDS),
    localparam int RAW = lc_rd_aw(LINE_WORDS, WR_WIDTH, RD_WIDTH)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_we,
    input  logic [WAW-1:0]      i_waddr,
    input  logic [WR_WIDTH-1:0] i_wdata,
    input  logic                i_re,
    input  logic [RAW-1:0]      i_raddr,
    output logic [RD_WIDTH-1:0] o_rdata
);
    localparam int SW = lc_sub_w(lc_ratio(WR_WIDTH, RD_WIDTH));

    logic [WR_WIDTH-1:0] r_mem [2*LINE_WORDS];
    logic [WR_WIDTH-1:0] r_word;
    logic [RAW-1:0]      r_sub;

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // Full word is read out; the element is picked after the register so the array stays WR_WIDTH wide.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_word <= '0;
            r_sub  <= '0;
        end else if (i_re) begin
            r_word <= r_mem[WAW'(i_raddr >> SW)];
            r_sub  <= i_raddr & RAW'((1 << SW) - 1);
        end
    end

    assign o_rdata = r_word[r_sub*RD_WIDTH +: RD_WIDTH];

endmodule

// File: rtl/linecache_pingpong.sv
// linecache_pingpong: double-buffered width-converting line cache; fills one bank while the other streams out.
module linecache_pingpong
    import linecache_pkg::*;
#(
    parameter int WR_WIDTH   = 4,
    parameter int RD_WIDTH   = 1,
    parameter int LINE_WORDS = 128
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_wr_valid,
    input  logic [WR_WIDTH-1:0] i_wr_data,
    output logic                o_wr_full,
    output logic                o_wr_overflow,
    input  logic                i_swap,
    input  logic                i_rd_en,
    output logic [RD_WIDTH-1:0] o_rd_data,
    output logic                o_rd_valid,
    output logic                o_rd_empty,
    output logic                o_bank_sel
);
    localparam int RATIO = lc_ratio(WR_WIDTH, RD_WIDTH);
    localparam int SW    = lc_sub_w(RATIO);
    localparam int WAW   = lc_wr_aw(LINE_WORDS);
    localparam int RAW   = lc_rd_aw(LINE_WORDS, WR_WIDTH, RD_WIDTH);
    localparam int WW    = $clog2(LINE_WORDS);
    localparam int WPW   = WW + 1;
    localparam int RPW   = $clog2(LINE_WORDS * RATIO) + 1;

    if (!lc_params_ok(LINE_WORDS, WR_WIDTH, RD_WIDTH)) begin : g_bad_params
        $error("linecache_pingpong: WR_WIDTH must be a multiple of RD_WIDTH and LINE_WORDS a power of two >= 2");
    end

    logic           r_bank;
    logic [WPW-1:0] r_wr_ptr;
    logic [RPW-1:0] r_rd_ptr;
    logic [RPW-1:0] r_rd_level;
    logic           r_overflow;
    logic           r_rd_valid;

    logic           w_full;
    logic           w_empty;
    logic           w_we;
    logic           w_re;
    logic [WPW-1:0] w_wr_ptr_nx;
    logic [RPW-1:0] w_level;
    logic [WW-1:0]  w_rd_word;
    logic [WAW-1:0] w_waddr;
    logic [RAW-1:0] w_raddr;

    assign w_full      = r_wr_ptr == WPW'(LINE_WORDS);
    assign w_empty     = r_rd_ptr == r_rd_level;
    assign w_we        = i_wr_valid && !w_full;
    assign w_re        = i_rd_en && !w_empty && !i_swap;
    assign w_wr_ptr_nx = r_wr_ptr + WPW'(w_we);
    // Level includes a word accepted in the swap cycle, since that write lands in the outgoing bank.
    assign w_level     = RPW'(w_wr_ptr_nx * RATIO);
    assign w_rd_word   = WW'(r_rd_ptr / RATIO);
    assign w_waddr     = {r_bank, r_wr_ptr[WW-1:0]};
    assign w_raddr     = (RAW'({~r_bank, w_rd_word}) << SW) | RAW'(r_rd_ptr % RATIO);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_bank     <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_rd_level <= '0;
            r_overflow <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_re;
            if (i_swap) begin
                r_bank     <= ~r_bank;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_rd_level <= w_level;
                r_overflow <= 1'b0;
            end else begin
                r_wr_ptr   <= w_wr_ptr_nx;
                r_rd_ptr   <= r_rd_ptr + RPW'(w_re);
                r_overflow <= r_overflow | (i_wr_valid && w_full);
            end
        end
    end

    linecache_sdpram #(
        .WR_WIDTH   (WR_WIDTH),
        .RD_WIDTH   (RD_WIDTH),
        .LINE_WORDS (LINE_WORDS)
    ) u_ram (
        .i_clk   (i_clk),
        .i_rst   (i_reset),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (i_wr_data),
        .i_re    (w_re),
        .i_raddr (w_raddr),
        .o_rdata (o_rd_data)
    );

    assign o_wr_full     = w_full;
    assign o_wr_overflow = r_overflow;
    assign o_rd_valid    = r_rd_valid;
    assign o_rd_empty    = w_empty;
    assign o_bank_sel    = r_bank;

endmodule
